esteira_sequencer: RTL and testbench

- Production-line controller for the conveyor design on the DE2 board.
- Queues product codes entered on the switches when the register switch rises.
- While production is enabled, it takes products one at a time from the queue and moves each across NSTATIONS conveyor positions at a fixed tick rate.
- Drives the station LEDs, the current product code, the completed-item count and the end-of-batch flag that feed the board's LED, HEX and LCD logic.

---
 rtl/esteira_pkg.sv | 15 +
 rtl/esteira_fifo.sv | 58 +++++
 rtl/esteira_sequencer.sv | 140 ++++++++++++++
 tb/tb_esteira_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esteira_pkg.sv
// Shared types and constants for the conveyor production-line sequencer.
package esteira_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MOVE,
        UNLOAD
    } state_t;

    localparam int                CODE_W       = 4;
    localparam logic [CODE_W-1:0] INVALID_CODE = '0;
    localparam int                DONE_MAX     = 99;

endpackage

// File: rtl/esteira_fifo.sv
// Product-code queue: synchronous FIFO with first-word-fall-through read.
module esteira_fifo
    import esteira_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [CODE_W-1:0]         i_data,
    output logic [CODE_W-1:0]         o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(QDEPTH):0]   o_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [CODE_W-1:0] r_mem [QDEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(QDEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A push into a full queue is allowed when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/esteira_sequencer.sv
// Conveyor sequencer: queues product codes and walks each one across the
// station LEDs at a fixed tick rate, tracking completions and batch end.
module esteira_sequencer
    import esteira_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int QDEPTH    = 8,
    parameter int NSTATIONS = 10
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET,
    input  logic [CODE_W-1:0]         item_code,
    input  logic                      reg_sw,
    input  logic                      prod_sw,
    input  logic                      hold_sw,
    output logic [NSTATIONS-1:0]      station_leds,
    output logic [CODE_W-1:0]         cur_code,
    output logic                      busy,
    output logic                      fim,
    output logic [6:0]                done_count,
    output logic [$clog2(QDEPTH):0]   queue_count,
    output logic                      err
);

    localparam int TW = $clog2(TICK_DIV);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_reg_q;
    logic [TW-1:0]     r_tick;

    logic              w_push_req;
    logic              w_push_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CODE_W-1:0] w_head;
    logic              w_tick_wrap;
    logic              w_at_end;

    logic [NSTATIONS-1:0] w_leds_n;
    logic [CODE_W-1:0]    w_code_n;
    logic [6:0]           w_done_n;
    logic [TW-1:0]        w_tick_n;
    logic                 w_fim_n;
    logic                 w_err_n;
    logic                 w_busy_n;

    assign w_push_req    = reg_sw && !r_reg_q;
    assign w_pop         = (r_state == LOAD);
    assign w_push_accept = w_push_req && (item_code != INVALID_CODE) && (!w_full || w_pop);
    assign w_tick_wrap   = (r_tick == TW'(TICK_DIV - 1));
    assign w_at_end      = station_leds[NSTATIONS-1];

    esteira_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .i_push  (w_push_accept),
        .i_pop   (w_pop),
        .i_data  (item_code),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queue_count)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (prod_sw && !w_empty) w_next_state = LOAD;
            LOAD:    w_next_state = MOVE;
            MOVE:    if (!hold_sw && w_tick_wrap && w_at_end) w_next_state = UNLOAD;
            UNLOAD:  w_next_state = (prod_sw && !w_empty) ? LOAD : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_leds_n = station_leds;
        w_code_n = cur_code;
        w_done_n = done_count;
        w_tick_n = r_tick;
        w_fim_n  = fim;
        w_err_n  = err;
        w_busy_n = (w_next_state != IDLE);
        case (r_state)
            LOAD: begin
                w_code_n = w_head;
                w_leds_n = NSTATIONS'(1);
                w_tick_n = '0;
            end
            MOVE: begin
                if (!hold_sw) begin
                    w_tick_n = w_tick_wrap ? '0 : r_tick + TW'(1);
                    if (w_tick_wrap && !w_at_end) w_leds_n = station_leds << 1;
                end
            end
            UNLOAD: begin
                w_leds_n = '0;
                w_code_n = '0;
                if (done_count < 7'(DONE_MAX)) w_done_n = done_count + 7'd1;
                if (w_next_state == IDLE && w_empty) w_fim_n = 1'b1;
            end
            default: ;
        endcase
        // An accepted push reopens the batch even if it coincides with its end.
        if (w_push_accept)   w_fim_n = 1'b0;
        else if (w_push_req) w_err_n = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_reg_q      <= 1'b0;
            r_tick       <= '0;
            station_leds <= '0;
            cur_code     <= '0;
            busy         <= 1'b0;
            fim          <= 1'b0;
            done_count   <= '0;
            err          <= 1'b0;
        end else begin
            r_reg_q      <= reg_sw;
            r_tick       <= w_tick_n;
            station_leds <= w_leds_n;
            cur_code     <= w_code_n;
            busy         <= w_busy_n;
            fim          <= w_fim_n;
            done_count   <= w_done_n;
            err          <= w_err_n;
        end
    end

endmodule

// File: tb/tb_esteira_sequencer.sv
// Self-checking bench for esteira_sequencer: directed scenarios plus a long
// randomized run, all compared against a belt-time reference model.
module tb_esteira_sequencer;

   localparam int TD  = 4;
   localparam int QD  = 4;
   localparam int NST = 10;

   logic       CLOCK_50 = 1'b0;
   logic       RESET    = 1'b1;
   logic [3:0] item_code = 4'd0;
   logic       reg_sw   = 1'b0;
   logic       prod_sw  = 1'b0;
   logic       hold_sw  = 1'b0;

   logic [NST-1:0] station_leds;
   logic [3:0]     cur_code;
   logic           busy;
   logic           fim;
   logic [6:0]     done_count;
   logic [2:0]     queue_count;
   logic           err;

   int passCount  = 0;
   int failCount  = 0;
   int totalCount = 0;

   // Reference model: a queue of codes plus elapsed active belt time per item.
   logic [3:0]     mQ[$];
   bit             mRegQ;
   bit             mLoading;
   bit             mOnBelt;
   bit             mUnloading;
   int             mElapsed;
   int             mCompletions;
   logic [NST-1:0] eLeds;
   logic [3:0]     eCode;
   logic           eBusy;
   logic           eFim;
   logic [6:0]     eDone;
   logic [2:0]     eQcnt;
   logic           eErr;

   esteira_sequencer #(
      .TICK_DIV  (TD),
      .QDEPTH    (QD),
      .NSTATIONS (NST)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .RESET        (RESET),
      .item_code    (item_code),
      .reg_sw       (reg_sw),
      .prod_sw      (prod_sw),
      .hold_sw      (hold_sw),
      .station_leds (station_leds),
      .cur_code     (cur_code),
      .busy         (busy),
      .fim          (fim),
      .done_count   (done_count),
      .queue_count  (queue_count),
      .err          (err)
   );

   // 50 MHz-style free-running clock; only relative timing matters here.
   always #5 CLOCK_50 = ~CLOCK_50;

   // Advances the model by one clock edge using the inputs seen at that edge.
   task automatic modelStep();
      bit pushReq;
      bit preEmpty;
      bit full;
      bit accept;
      if (RESET) begin
         mQ.delete();
         mRegQ = 0; mLoading = 0; mOnBelt = 0; mUnloading = 0;
         mElapsed = 0; mCompletions = 0;
         eLeds = '0; eCode = '0; eFim = 0; eDone = '0; eErr = 0;
      end else begin
         pushReq  = reg_sw && !mRegQ;
         preEmpty = (mQ.size() == 0);
         full     = (mQ.size() == QD);
         accept   = pushReq && (item_code != 4'd0) && (!full || mLoading);
         if (mLoading) begin
            eCode    = mQ.pop_front();
            mElapsed = 0;
            eLeds    = NST'(1);
            mLoading = 0;
            mOnBelt  = 1;
         end else if (mOnBelt) begin
            if (!hold_sw) begin
               mElapsed++;
               if (mElapsed == NST * TD) begin
                  mOnBelt    = 0;
                  mUnloading = 1;
               end else begin
                  eLeds = NST'(1) << (mElapsed / TD);
               end
            end
         end else if (mUnloading) begin
            mUnloading = 0;
            mCompletions++;
            if (eDone < 7'd99) eDone = eDone + 7'd1;
            eLeds = '0;
            eCode = '0;
            if (prod_sw && !preEmpty) mLoading = 1;
            else if (preEmpty)        eFim = 1;
         end else if (prod_sw && !preEmpty) begin
            mLoading = 1;
         end
         if (accept) begin
            mQ.push_back(item_code);
            eFim = 0;
         end else if (pushReq) begin
            eErr = 1;
         end
         mRegQ = reg_sw;
      end
      eBusy = mLoading || mOnBelt || mUnloading;
      eQcnt = 3'(mQ.size());
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkValue("station_leds", 32'(station_leds), 32'(eLeds));
      checkValue("cur_code",     32'(cur_code),     32'(eCode));
      checkValue("busy",         32'(busy),         32'(eBusy));
      checkValue("fim",          32'(fim),          32'(eFim));
      checkValue("done_count",   32'(done_count),   32'(eDone));
      checkValue("queue_count",  32'(queue_count),  32'(eQcnt));
      checkValue("err",          32'(err),          32'(eErr));
   endtask

   task automatic applyStimulus(input logic rst, input logic [3:0] code,
                                input logic rs, input logic ps, input logic hs);
      RESET     = rst;
      item_code = code;
      reg_sw    = rs;
      prod_sw   = ps;
      hold_sw   = hs;
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      modelStep();
      @(negedge CLOCK_50);
      checkOutput();
   endtask

   task automatic stepN(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic timeoutFail(input string tag);
      totalCount++;
      failCount++;
      $error("[TB] FAIL %s: observed timeout expected completion", tag);
   endtask

   task automatic doReset();
      applyStimulus(1, 4'd0, 0, 0, 0);
      stepN(2);
      applyStimulus(0, 4'd0, 0, 0, 0);
      step();
   endtask

   task automatic pushCode(input logic [3:0] code);
      applyStimulus(0, code, 1, prod_sw, hold_sw);
      step();
      applyStimulus(0, code, 0, prod_sw, hold_sw);
      step();
   endtask

   task automatic runUntilLeds(input logic [NST-1:0] target, input string tag);
      int n = 0;
      while (eLeds != target && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) timeoutFail(tag);
   endtask

   task automatic runUntilIdle(input string tag);
      int n = 0;
      while ((mLoading || mOnBelt || mUnloading || (prod_sw && mQ.size() > 0)) && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) timeoutFail(tag);
   endtask

   initial begin
      int n;
      logic [3:0] code;
      logic rs;
      logic hs;

      $display("[TB] reset and single enqueue");
      applyStimulus(1, 4'd0, 0, 0, 0);
      stepN(2);
      checkValue("rst_leds", 32'(station_leds), 32'd0);
      checkValue("rst_qcnt", 32'(queue_count), 32'd0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      step();
      pushCode(4'd5);
      checkValue("enq_qcnt", 32'(queue_count), 32'd1);
      checkValue("enq_err",  32'(err),         32'd0);

      $display("[TB] two-item batch");
      doReset();
      pushCode(4'd3);
      pushCode(4'd7);
      applyStimulus(0, 4'd0, 0, 1, 0);
      runUntilLeds(NST'(1), "first_load");
      checkValue("first_code", 32'(cur_code), 32'd3);
      runUntilIdle("batch_end");
      step();
      checkValue("batch_done", 32'(done_count), 32'd2);
      checkValue("batch_fim",  32'(fim),        32'd1);
      checkValue("batch_busy", 32'(busy),       32'd0);

      $display("[TB] overflow and invalid code");
      doReset();
      for (int i = 0; i < 5; i++) pushCode(4'(1 + $urandom_range(14, 0)));
      checkValue("ovf_qcnt", 32'(queue_count), 32'd4);
      checkValue("ovf_err",  32'(err),         32'd1);
      doReset();
      pushCode(4'd0);
      checkValue("zero_err",  32'(err),         32'd1);
      checkValue("zero_qcnt", 32'(queue_count), 32'd0);

      $display("[TB] hold freezes the belt");
      doReset();
      pushCode(4'd9);
      applyStimulus(0, 4'd0, 0, 1, 0);
      runUntilLeds(NST'(8), "reach_pos3");
      applyStimulus(0, 4'd0, 0, 1, 1);
      stepN(20);
      checkValue("hold_pos", 32'(station_leds), 32'h008);
      applyStimulus(0, 4'd0, 0, 1, 0);
      runUntilIdle("hold_end");

      $display("[TB] production drop and mid-move reset");
      doReset();
      pushCode(4'd2);
      pushCode(4'd4);
      pushCode(4'd6);
      applyStimulus(0, 4'd0, 0, 1, 0);
      runUntilLeds(NST'(16), "reach_pos4");
      applyStimulus(0, 4'd0, 0, 0, 0);
      runUntilIdle("drop_end");
      step();
      checkValue("drop_qcnt", 32'(queue_count), 32'd2);
      checkValue("drop_fim",  32'(fim),         32'd0);
      checkValue("drop_busy", 32'(busy),        32'd0);
      applyStimulus(0, 4'd0, 0, 1, 0);
      runUntilLeds(NST'(4), "reach_pos2");
      applyStimulus(1, 4'd0, 0, 1, 0);
      step();
      checkValue("mrst_leds", 32'(station_leds), 32'd0);
      checkValue("mrst_code", 32'(cur_code),     32'd0);
      checkValue("mrst_busy", 32'(busy),         32'd0);
      checkValue("mrst_qcnt", 32'(queue_count),  32'd0);

      $display("[TB] full-queue push during load, then saturation run");
      doReset();
      for (int i = 0; i < 4; i++) pushCode(4'(1 + i));
      applyStimulus(0, 4'd0, 0, 1, 0);
      step();
      applyStimulus(0, 4'd6, 1, 1, 0);
      step();
      checkValue("fullpop_qcnt", 32'(queue_count), 32'd4);
      checkValue("fullpop_err",  32'(err),         32'd0);
      applyStimulus(0, 4'd6, 0, 1, 0);
      step();
      n = 0;
      while (mCompletions < 100 && n < 20000) begin
         rs   = 1'b0;
         code = 4'd0;
         if (!reg_sw && mQ.size() < QD && $urandom_range(1, 0) == 1) begin
            rs   = 1'b1;
            code = 4'($urandom_range(15, 0));
         end
         hs = ($urandom_range(7, 0) == 0);
         applyStimulus(0, code, rs, 1, hs);
         step();
         n++;
      end
      if (n >= 20000) timeoutFail("saturation_run");
      step();
      checkValue("done_sat", 32'(done_count), 32'd99);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
